dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data memory (`dataMem`) between the core's load/store path and an external requester (loader/debug/DMA). The arbiter sits between the ALU-address/regFile-data side of the core and `dataMem`. It grants one requester per cycle, raises `stall` to freeze the core's PC while the core's access is deferred, and enforces round-robin fairness with a bounded external burst lock.

---
 rtl/dmem_arbiter_pkg.sv | 25 ++
 rtl/dmem_arbiter.sv | 99 +++++++++
 tb/tb_dmem_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: owner states, round-robin
// "last" values and the muxed memory request bundle.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_CORE       = 2'd1,
    ARB_EXT        = 2'd2,
    ARB_EXT_LOCKED = 2'd3
  } arb_state_e;

  localparam logic LAST_CORE = 1'b0;
  localparam logic LAST_EXT  = 1'b1;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of the single-port dataMem,
// with a bounded external burst lock and a stall output for the core.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_wEn,
  input  logic [31:0] core_address,
  input  logic [31:0] core_dataWrite,
  output logic        core_gnt,
  output logic [31:0] core_dataRead,
  output logic        stall,
  input  logic        ext_req,
  input  logic        ext_lock,
  input  logic        ext_wEn,
  input  logic [31:0] ext_address,
  input  logic [31:0] ext_dataWrite,
  output logic        ext_gnt,
  output logic [31:0] ext_dataRead,
  output logic        mem_wEn,
  output logic [31:0] mem_address,
  output logic [31:0] mem_dataWrite,
  input  logic [31:0] mem_dataRead
);

  arb_state_e state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] burst_cnt, burst_nxt;
  logic       core_pick, ext_pick;
  mem_req_t   core_mreq, ext_mreq, sel_mreq;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      last      <= LAST_EXT;
      burst_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  always_comb begin
    core_pick = 1'b0;
    ext_pick  = 1'b0;
    state_nxt = ARB_IDLE;
    last_nxt  = last;
    burst_nxt = 8'd0;
    // A held lock keeps ext on the port until the core has waited MAX_BURST grants.
    if (state == ARB_EXT_LOCKED && ext_req && (!core_req || burst_cnt < 8'(MAX_BURST)))
      ext_pick = 1'b1;
    else if (core_req && ext_req) begin
      if (last == LAST_CORE) ext_pick  = 1'b1;
      else                   core_pick = 1'b1;
    end else begin
      core_pick = core_req;
      ext_pick  = ext_req;
    end

    if (core_pick) begin
      state_nxt = ARB_CORE;
      last_nxt  = LAST_CORE;
    end else if (ext_pick) begin
      last_nxt = LAST_EXT;
      if (ext_lock) begin
        state_nxt = ARB_EXT_LOCKED;
        burst_nxt = sat_inc(burst_cnt);
      end else begin
        state_nxt = ARB_EXT;
      end
    end
  end

  // Grants are masked by reset directly so an async reset kills the access mid-cycle.
  assign core_gnt  = core_pick & ~reset;
  assign ext_gnt   = ext_pick  & ~reset;
  assign stall     = core_req & ~core_gnt & ~reset;

  assign core_mreq = '{wen: core_wEn, addr: core_address, wdata: core_dataWrite};
  assign ext_mreq  = '{wen: ext_wEn,  addr: ext_address,  wdata: ext_dataWrite};

  always_comb begin
    sel_mreq = '0;
    if (core_gnt)     sel_mreq = core_mreq;
    else if (ext_gnt) sel_mreq = ext_mreq;
  end

  assign mem_wEn       = sel_mreq.wen;
  assign mem_address   = sel_mreq.addr;
  assign mem_dataWrite = sel_mreq.wdata;
  assign core_dataRead = reset ? 32'd0 : mem_dataRead;
  assign ext_dataRead  = reset ? 32'd0 : mem_dataRead;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter against a behavioural
// ownership/fairness model and a reference copy of the data memory.
module tb_dmem_arbiter;

  localparam int MAX_BURST = 4;

  logic        clock, reset;
  logic        core_req, core_wEn, core_gnt, stall;
  logic [31:0] core_address, core_dataWrite, core_dataRead;
  logic        ext_req, ext_lock, ext_wEn, ext_gnt;
  logic [31:0] ext_address, ext_dataWrite, ext_dataRead;
  logic        mem_wEn;
  logic [31:0] mem_address, mem_dataWrite, mem_dataRead;

  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_wEn(core_wEn), .core_address(core_address),
    .core_dataWrite(core_dataWrite), .core_gnt(core_gnt),
    .core_dataRead(core_dataRead), .stall(stall),
    .ext_req(ext_req), .ext_lock(ext_lock), .ext_wEn(ext_wEn),
    .ext_address(ext_address), .ext_dataWrite(ext_dataWrite),
    .ext_gnt(ext_gnt), .ext_dataRead(ext_dataRead),
    .mem_wEn(mem_wEn), .mem_address(mem_address),
    .mem_dataWrite(mem_dataWrite), .mem_dataRead(mem_dataRead)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment memory driven by the DUT; ref_mem is what it should hold.
  logic [31:0] env_mem [0:255];
  logic [31:0] ref_mem [0:255];
  initial for (int i = 0; i < 256; i++) begin env_mem[i] = 32'd0; ref_mem[i] = 32'd0; end
  assign mem_dataRead = env_mem[mem_address[9:2]];
  always @(posedge clock) if (mem_wEn) env_mem[mem_address[9:2]] <= mem_dataWrite;

  // Model: who owns the port now, from the previous owner, lock run length and fairness bit.
  logic m_locked, m_last_ext;
  int   m_run;
  logic e_core, e_ext;

  always_comb begin
    e_core = 1'b0;
    e_ext  = 1'b0;
    if (!reset) begin
      if (m_locked && ext_req && (!core_req || m_run < MAX_BURST)) e_ext = 1'b1;
      else if (core_req && ext_req) begin
        if (m_last_ext) e_core = 1'b1;
        else            e_ext  = 1'b1;
      end else begin
        e_core = core_req;
        e_ext  = ext_req;
      end
    end
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_locked <= 1'b0; m_last_ext <= 1'b1; m_run <= 0;
    end else if (e_core) begin
      m_locked <= 1'b0; m_last_ext <= 1'b0; m_run <= 0;
      if (core_wEn) ref_mem[core_address[9:2]] <= core_dataWrite;
    end else if (e_ext) begin
      m_locked <= ext_lock; m_last_ext <= 1'b1;
      m_run <= ext_lock ? ((m_run >= 255) ? 255 : m_run + 1) : 0;
      if (ext_wEn) ref_mem[ext_address[9:2]] <= ext_dataWrite;
    end else begin
      m_locked <= 1'b0; m_run <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    chk("core_gnt", {31'd0, core_gnt}, {31'd0, e_core});
    chk("ext_gnt",  {31'd0, ext_gnt},  {31'd0, e_ext});
    chk("stall",    {31'd0, stall},    {31'd0, !reset && core_req && !e_core});
    chk("mem_wEn",  {31'd0, mem_wEn},
        {31'd0, e_core ? core_wEn : (e_ext ? ext_wEn : 1'b0)});
    chk("mem_address", mem_address,
        e_core ? core_address : (e_ext ? ext_address : 32'd0));
    chk("mem_dataWrite", mem_dataWrite,
        e_core ? core_dataWrite : (e_ext ? ext_dataWrite : 32'd0));
    if (e_core) chk("core_dataRead", core_dataRead, ref_mem[core_address[9:2]]);
    if (e_ext)  chk("ext_dataRead",  ext_dataRead,  ref_mem[ext_address[9:2]]);
    if (reset) begin
      chk("core_dataRead_rst", core_dataRead, 32'd0);
      chk("ext_dataRead_rst",  ext_dataRead,  32'd0);
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [7:0] w;
    w = 8'($urandom);
    return {22'd0, w, 2'b00};
  endfunction

  logic c_hold, e_hold;

  initial begin
    reset = 1'b1;
    core_req = 1'b1; core_wEn = 1'b1; core_address = 32'h10; core_dataWrite = 32'h55;
    ext_req = 1'b1; ext_lock = 1'b1; ext_wEn = 1'b1; ext_address = 32'h20; ext_dataWrite = 32'h66;
    #3;
    chk("rst_core_gnt", {31'd0, core_gnt}, 32'd0);
    chk("rst_ext_gnt",  {31'd0, ext_gnt},  32'd0);
    chk("rst_mem_wEn",  {31'd0, mem_wEn},  32'd0);
    chk("rst_stall",    {31'd0, stall},    32'd0);
    step();
    core_req = 1'b0; ext_req = 1'b0; ext_lock = 1'b0; ext_wEn = 1'b0; core_wEn = 1'b0;
    step(); reset = 1'b0;

    // Core-only write then read-back.
    core_req = 1'b1; core_wEn = 1'b1; core_address = 32'h10; core_dataWrite = 32'hDEADBEEF;
    #3;
    chk("co_wr_gnt", {31'd0, core_gnt}, 32'd1);
    chk("co_wr_stall", {31'd0, stall}, 32'd0);
    chk("co_wr_addr", mem_address, 32'h10);
    step(); core_wEn = 1'b0; #3;
    chk("co_rd_gnt", {31'd0, core_gnt}, 32'd1);
    chk("co_rd_data", core_dataRead, 32'hDEADBEEF);
    step(); core_req = 1'b0;

    // Tie after reset: core, ext (core stalled), core.
    reset = 1'b1; step(); reset = 1'b0;
    core_req = 1'b1; ext_req = 1'b1; #3;
    chk("tie0_core", {31'd0, core_gnt}, 32'd1);
    step(); #3;
    chk("tie1_ext", {31'd0, ext_gnt}, 32'd1);
    chk("tie1_stall", {31'd0, stall}, 32'd1);
    step(); #3;
    chk("tie2_core", {31'd0, core_gnt}, 32'd1);
    step();

    // Locked burst under contention: four ext grants, then core.
    ext_lock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("burst_ext",   {31'd0, ext_gnt},  {31'd0, i < 4});
      chk("burst_core",  {31'd0, core_gnt}, {31'd0, i == 4});
      chk("burst_stall", {31'd0, stall},    {31'd0, i < 4});
      step();
    end

    // Lock with no contention never blocks, even past MAX_BURST.
    core_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #3; chk("nolock_ext", {31'd0, ext_gnt}, 32'd1);
      step();
    end
    core_req = 1'b1; #3;
    chk("after_long_lock_core", {31'd0, core_gnt}, 32'd1);
    step();

    // Async reset in the second burst cycle.
    ext_wEn = 1'b1; ext_address = 32'h40; ext_dataWrite = 32'h1234;
    #3; chk("rb_entry_ext", {31'd0, ext_gnt}, 32'd1);
    step(); #2;
    chk("rb_c2_ext", {31'd0, ext_gnt}, 32'd1);
    chk("rb_c2_wen", {31'd0, mem_wEn}, 32'd1);
    reset = 1'b1; #1;
    chk("rb_async_ext", {31'd0, ext_gnt}, 32'd0);
    chk("rb_async_wen", {31'd0, mem_wEn}, 32'd0);
    chk("rb_async_stall", {31'd0, stall}, 32'd0);
    step(); reset = 1'b0; ext_wEn = 1'b0; #3;
    chk("rb_tie_core", {31'd0, core_gnt}, 32'd1);
    step();

    // Idle cycles keep the port quiet and preserve the round-robin bit.
    core_req = 1'b0; ext_req = 1'b0; ext_lock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("idle_wen",  {31'd0, mem_wEn}, 32'd0);
      chk("idle_addr", mem_address, 32'd0);
      step();
    end
    core_req = 1'b1; ext_req = 1'b1; #3;
    chk("idle_tie_ext", {31'd0, ext_gnt}, 32'd1);
    step();

    // Randomized traffic; deferred requesters hold their request and payload.
    c_hold = 1'b0; e_hold = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (reset) reset = 1'b0;
      else if ($urandom_range(199) == 0) reset = 1'b1;
      if (!c_hold) begin
        core_req = $urandom_range(9) < 6; core_wEn = 1'($urandom_range(1));
        core_address = rand_addr(); core_dataWrite = $urandom;
      end
      if (!e_hold) begin
        ext_req = $urandom_range(9) < 6; ext_wEn = 1'($urandom_range(1));
        ext_address = rand_addr(); ext_dataWrite = $urandom;
      end
      ext_lock = $urandom_range(9) < 7;
      #3;
      c_hold = core_req && !e_core && !reset;
      e_hold = ext_req && !e_ext && !reset;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
